// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR, one registered mux level per amount bit.
// Valid/ready on both sides with collapsing bubbles, flush and a tag passthrough.
module pipelined_shift_unit #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int AMT_W = $clog2(WIDTH),
    localparam int NSTG = AMT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    logic [NSTG-1:0]  r_v;
    logic [WIDTH-1:0] r_data [NSTG];
    logic [AMT_W-1:0] r_amt  [NSTG];
    logic [1:0]       r_op   [NSTG];
    logic             r_sign [NSTG];
    logic [TAG_W-1:0] r_tag  [NSTG];

    logic [NSTG-1:0]  w_adv;
    logic [NSTG-1:0]  w_src_v;
    logic [WIDTH-1:0] w_src_data [NSTG];
    logic [AMT_W-1:0] w_src_amt  [NSTG];
    logic [1:0]       w_src_op   [NSTG];
    logic             w_src_sign [NSTG];
    logic [TAG_W-1:0] w_src_tag  [NSTG];
    logic [WIDTH-1:0] w_shf      [NSTG];

    // Upper half of the double-width word supplies the fill bits.
    function automatic logic [WIDTH-1:0] f_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic             s,
        input int               n
    );
        logic [2*WIDTH-1:0] t;
        t = '0;
        unique case (op)
            2'b00: t = {{WIDTH{1'b0}}, d} << n;
            2'b01: t = {{WIDTH{1'b0}}, d} >> n;
            2'b10: t = {{WIDTH{s}}, d} >> n;
            2'b11: t = {d, d} >> n;
        endcase
        return t[WIDTH-1:0];
    endfunction

    always_comb begin
        w_adv = '0;
        w_adv[NSTG-1] = !r_v[NSTG-1] | out_ready;
        for (int k = NSTG - 2; k >= 0; k--) begin
            w_adv[k] = !r_v[k] | w_adv[k+1];
        end
    end

    assign in_ready = w_adv[0] & !flush & rst_n;

    always_comb begin
        w_src_v[0]    = in_valid & in_ready;
        w_src_data[0] = in_data;
        w_src_amt[0]  = in_amt;
        w_src_op[0]   = in_op;
        w_src_sign[0] = in_data[WIDTH-1];
        w_src_tag[0]  = in_tag;
        for (int k = 1; k < NSTG; k++) begin
            w_src_v[k]    = r_v[k-1];
            w_src_data[k] = r_data[k-1];
            w_src_amt[k]  = r_amt[k-1];
            w_src_op[k]   = r_op[k-1];
            w_src_sign[k] = r_sign[k-1];
            w_src_tag[k]  = r_tag[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            w_shf[k] = w_src_data[k];
            if (w_src_amt[k][k]) begin
                w_shf[k] = f_shift(w_src_data[k], w_src_op[k],
                                   w_src_sign[k], 1 << k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int k = 0; k < NSTG; k++) begin
                r_data[k] <= '0;
                r_amt[k]  <= '0;
                r_op[k]   <= '0;
                r_sign[k] <= 1'b0;
                r_tag[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (flush) begin
                    r_v[k] <= 1'b0;
                end else if (w_adv[k]) begin
                    r_v[k] <= w_src_v[k];
                end
                if (w_adv[k]) begin
                    r_data[k] <= w_shf[k];
                    r_amt[k]  <= w_src_amt[k];
                    r_op[k]   <= w_src_op[k];
                    r_sign[k] <= w_src_sign[k];
                    r_tag[k]  <= w_src_tag[k];
                end
            end
        end
    end

    assign out_valid = r_v[NSTG-1];
    assign out_data  = r_data[NSTG-1];
    assign out_tag   = r_tag[NSTG-1];
    assign out_zero  = ~|r_data[NSTG-1];

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Randomised and directed bench for pipelined_shift_unit.
// Scoreboard queue fed by an arithmetic shift model.
module tb_pipelined_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_amt = '0;
    logic [1:0]  in_op = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_zero;
    logic [3:0]  out_tag;

    pipelined_shift_unit #(.WIDTH(16), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  t;
    } exp_t;

    exp_t        q[$];
    int          n_tot = 0;
    int          n_bad = 0;
    int          n_in = 0;
    int          n_out = 0;
    logic [15:0] last_d = '0;
    logic [3:0]  last_t = '0;
    logic        last_z = 1'b0;
    bit          done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [1:0] op,
                                              input logic [15:0] d,
                                              input logic [3:0] a);
        int unsigned u;
        int sh;
        logic signed [15:0] s;
        u = d;
        sh = a;
        s = d;
        case (op)
            2'd0: return 16'(u << sh);
            2'd1: return 16'(u >> sh);
            2'd2: return s >>> sh;
            default: return 16'((u >> sh) | (u << (16 - sh)));
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data", out_data, e.d);
                    chk("tag", out_tag, e.t);
                    chk("zero", out_zero, e.d == 16'h0);
                end
                last_d = out_data;
                last_t = out_tag;
                last_z = out_zero;
                n_out++;
            end
            if (flush) q.delete();
            if (in_valid && in_ready) begin
                q.push_back('{ref_shift(in_op, in_data, in_amt), in_tag});
                n_in++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] op, input logic [15:0] d,
                       input logic [3:0] a, input logic [3:0] t,
                       output int waits);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_data = d;
        in_amt = a;
        in_tag = t;
        for (waits = 0; waits < 200; waits++) begin
            #2;
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic run1(input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] a, input logic [3:0] t,
                        input logic [15:0] exp);
        int w;
        int n0;
        n0 = n_out;
        put(op, d, a, t, w);
        for (int i = 0; i < 20 && n_out == n0; i++) cyc();
        chk("dir_data", last_d, exp);
    endtask

    task automatic lat_op(input logic [1:0] op, input logic [15:0] d,
                          input logic [3:0] a, input logic [3:0] t,
                          input logic [15:0] exp);
        int w;
        int lat;
        int n0;
        n0 = n_out;
        put(op, d, a, t, w);
        chk("lat_accept", w, 0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            cyc();
            lat++;
        end
        chk("latency", lat, 4);
        for (int i = 0; i < 20 && n_out == n0; i++) cyc();
        chk("lat_data", last_d, exp);
        chk("lat_tag", last_t, t);
    endtask

    initial begin
        int w;
        int n0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_od", out_data, 0);
        chk("rst_oz", out_zero, 1);
        chk("rst_ot", out_tag, 0);
        chk("rst_ir", in_ready, 0);
        rst_n = 1'b1;
        #2;
        chk("rel_ir", in_ready, 1);
        @(posedge clk);
        #1;

        lat_op(2'b11, 16'h8001, 4'd1, 4'd3, 16'hC000);

        run1(2'b10, 16'h8000, 4'd15, 4'd1, 16'hFFFF);
        run1(2'b01, 16'h8000, 4'd15, 4'd2, 16'h0001);
        run1(2'b11, 16'h8000, 4'd15, 4'd3, 16'h0001);
        run1(2'b00, 16'h0001, 4'd15, 4'd4, 16'h8000);
        run1(2'b01, 16'h0001, 4'd1, 4'd5, 16'h0000);
        chk("srl_zero", last_z, 1);

        n0 = n_out;
        for (int i = 0; i < 4; i++) begin
            put(2'(i), 16'hA5C3, 4'd0, 4'(8 + i), w);
            chk("amt0_b2b", w, 0);
        end
        repeat (6) cyc();
        chk("amt0_cnt", n_out - n0, 4);
        chk("amt0_last", last_d, 16'hA5C3);
        chk("amt0_tag", last_t, 11);

        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    put(2'($urandom_range(0, 3)), 16'($urandom),
                        4'($urandom_range(0, 15)), 4'(i), w);
                end
            end
            begin
                out_ready = 1'b1;
                repeat (3) cyc();
                out_ready = 1'b0;
                repeat (4) cyc();
                #2;
                chk("stall_ir", in_ready, 0);
                chk("stall_ov", out_valid, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (8) cyc();
        chk("stream_cnt", n_out - n0, 10);
        chk("stream_tag", last_t, 9);

        n0 = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(2'($urandom_range(0, 3)), 16'($urandom),
                4'($urandom_range(0, 15)), 4'(i), w);
            chk("gap_accept", w, 0);
            repeat (2) cyc();
        end
        #2;
        chk("gap_full_ir", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (6) cyc();
        chk("gap_cnt", n_out - n0, 4);

        n0 = n_out;
        for (int i = 0; i < 3; i++) begin
            put(2'b00, 16'h1234, 4'(i), 4'(i), w);
        end
        flush = 1'b1;
        #2;
        chk("flush_ir", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_ov", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("flush_empty", out_valid, 0);
        end
        chk("flush_cnt", n_out - n0, 0);
        lat_op(2'b10, 16'h9000, 4'd4, 4'd6, 16'hF900);

        n0 = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(2'b01, 16'hF0F0, 4'(i + 1), 4'(i), w);
        end
        repeat (2) cyc();
        chk("pre_rst_ov", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", out_valid, 0);
        chk("arst_od", out_data, 0);
        chk("arst_oz", out_zero, 1);
        chk("arst_ot", out_tag, 0);
        chk("arst_ir", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        lat_op(2'b00, 16'h00FF, 4'd8, 4'd12, 16'hFF00);
        chk("rst_cnt", n_out - n0, 1);

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    put(2'($urandom_range(0, 3)), 16'($urandom),
                        4'($urandom_range(0, 15)), 4'($urandom), w);
                    repeat ($urandom_range(0, 2)) cyc();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    flush = ($urandom_range(0, 59) == 0);
                    cyc();
                end
                flush = 1'b0;
                out_ready = 1'b1;
            end
        join
        repeat (10) cyc();
        chk("drain_q", q.size(), 0);
        chk("drain_ov", out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
